// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO pair, with MTHI/MTLO write access.
// Build option: define MULDIV_EARLY_OUT_EN to let a multiply finish once its multiplier is exhausted.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_cpu,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr_en,
    input  logic             lo_wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state, state_nxt;

    logic [1:0]         op_q;
    logic               neg_res;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [CNT_W-1:0]   cnt;

    // Multiply: acc is the product, mcand the shifted multiplicand, mplier the shrinking multiplier.
    // Divide: acc = {remainder, dividend/quotient shift register}, mplier holds the divisor.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    logic               load, iterate, fix, commit, mt_open;
    logic               last_iter, mul_exhausted;
    logic               is_signed_in;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_qbit;
    logic [WIDTH-1:0]   div_rem_nxt;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_signed_in = ~op[0];
    assign abs_a = (is_signed_in && a[WIDTH-1]) ? -a : a;
    assign abs_b = (is_signed_in && b[WIDTH-1]) ? -b : b;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign div_shift   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, mplier};
    assign div_qbit    = ~div_diff[WIDTH];
    assign div_rem_nxt = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

    assign quo_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_exhausted = ~op_q[1] && (mplier[WIDTH-1:1] == '0);
`else
    assign mul_exhausted = 1'b0;
`endif

    assign last_iter = (cnt == CNT_ONE) || mul_exhausted;

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_iter) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b1;
        load    = 1'b0;
        iterate = 1'b0;
        fix     = 1'b0;
        commit  = 1'b0;
        mt_open = 1'b0;
        case (state)
            S_IDLE: begin
                busy    = 1'b0;
                load    = start;
                mt_open = 1'b1;
            end
            S_RUN:   iterate = 1'b1;
            S_FIX:   fix     = 1'b1;
            S_DONE:  commit  = 1'b1;
            default: busy    = 1'b0;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            a_raw   <= '0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (load) begin
            op_q    <= op;
            neg_res <= is_signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem <= is_signed_in && a[WIDTH-1];
            b_zero  <= (b == '0);
            a_raw   <= a;
            cnt     <= CNT_INIT;
            mplier  <= abs_b;
            if (op[1]) begin
                acc   <= {{WIDTH{1'b0}}, abs_a};
                mcand <= '0;
            end else begin
                acc   <= '0;
                mcand <= {{WIDTH{1'b0}}, abs_a};
            end
        end else if (iterate) begin
            cnt <= cnt - CNT_ONE;
            if (op_q[1]) begin
                acc <= {div_rem_nxt, acc[WIDTH-2:0], div_qbit};
            end else begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end else if (fix) begin
            if (op_q[1]) begin
                // Divide by zero reports the untouched dividend and an all-ones quotient.
                if (b_zero) acc <= {a_raw, {WIDTH{1'b1}}};
                else        acc <= {rem_fix, quo_fix};
            end else if (neg_res) begin
                acc <= -acc;
            end
        end
    end

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                hi <= acc[2*WIDTH-1:WIDTH];
                lo <= acc[WIDTH-1:0];
                if (op_q[1] && b_zero) div_zero <= 1'b1;
            end else if (mt_open) begin
                if (hi_wr_en) hi <= wr_data;
                if (lo_wr_en) lo <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit (WIDTH=32), hand-computed expected values.
module tb_muldiv_hilo_unit;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic         clk_cpu  = 1'b0;
    logic         reset    = 1'b0;
    logic         start    = 1'b0;
    logic [1:0]   op       = '0;
    logic [W-1:0] a        = '0;
    logic [W-1:0] b        = '0;
    logic         hi_wr_en = 1'b0;
    logic         lo_wr_en = 1'b0;
    logic [W-1:0] wr_data  = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_hilo_unit #(.WIDTH(W)) dut (
        .clk_cpu  (clk_cpu),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_wr_en (hi_wr_en),
        .lo_wr_en (lo_wr_en),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected start-to-done edge count for a multiply whose |b| is babs.
    function automatic int mul_lat(input logic [W-1:0] babs);
        int hb;
        hb = -1;
        if (!EARLY) return W + 2;
        for (int i = 0; i < W; i++) if (babs[i]) hb = i;
        return (hb < 0) ? 3 : hb + 3;
    endfunction

    // Start an op, scramble op/a/b afterwards, optionally MTHI with start and inject a
    // second start plus MTLO while busy. Returns at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int inj, input bit mt_hi,
                          output int lat, output bit busy_ok,
                          output logic [W-1:0] hi_at1, output logic [W-1:0] lo_after_inj);
        @(negedge clk_cpu);
        start    = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        hi_wr_en = mt_hi;
        wr_data  = 32'hAAAA_5555;
        @(negedge clk_cpu);
        hi_at1   = hi;
        start    = 1'b0;
        hi_wr_en = 1'b0;
        op       = ~o;
        a        = ~x;
        b        = '0;
        lat          = -1;
        busy_ok      = 1'b1;
        lo_after_inj = lo;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk_cpu);
            start    = 1'b0;
            lo_wr_en = 1'b0;
            if (inj > 0 && i == inj + 1) lo_after_inj = lo;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (i == inj) begin
                start    = 1'b1;
                op       = OP_DIVU;
                a        = 32'd100;
                b        = 32'd7;
                lo_wr_en = 1'b1;
                wr_data  = 32'h55;
            end
        end
        start    = 1'b0;
        lo_wr_en = 1'b0;
    endtask

    typedef struct {
        string        name;
        logic [1:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        int           exp_lat;
    } vec_t;

    initial begin
        int           lat;
        bit           busy_ok;
        logic [W-1:0] hi_at1, lo_inj;
        int           extra_done;
        int           inj_cycle;
        vec_t         vecs[6];

        repeat (2) @(negedge clk_cpu);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b1;

        @(negedge clk_cpu);
        lo_wr_en = 1'b1;
        hi_wr_en = 1'b1;
        wr_data  = 32'h55;
        @(negedge clk_cpu);
        lo_wr_en = 1'b0;
        hi_wr_en = 1'b0;
        check("mtlo_idle", lo, 32'h55);
        check("mthi_idle", hi, 32'h55);

        // MULT -3 * 5 = -15
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 1'b0, lat, busy_ok, hi_at1, lo_inj);
        check("mult_lat", lat, mul_lat(32'd5));
        check("mult_busy_during", busy_ok, 1);
        check("mult_busy_at_done", busy, 0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);
        @(negedge clk_cpu);
        check("mult_done_pulse", done, 0);

        // DIV 7 / -2 with MTHI in the start cycle: write lands, result overwrites it
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 1'b1, lat, busy_ok, hi_at1, lo_inj);
        check("start_mthi_lands", hi_at1, 32'hAAAA_5555);
        check("div_lat", lat, W + 2);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'h1);

        vecs[0] = '{"divu_100_7",    OP_DIVU,  32'd100,      32'd7,        32'h2,         32'hE,         W + 2};
        vecs[1] = '{"div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 2};
        vecs[2] = '{"div_ovf",       OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,       32'h8000_0000, W + 2};
        vecs[3] = '{"multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,       mul_lat(32'hFFFF_FFFF)};
        vecs[4] = '{"mult_min_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,       mul_lat(32'h8000_0000)};
        vecs[5] = '{"multu_3_5",     OP_MULTU, 32'd3,        32'd5,        32'h0,         32'hF,         mul_lat(32'd5)};
        foreach (vecs[k]) begin
            run_op(vecs[k].o, vecs[k].x, vecs[k].y, 0, 1'b0, lat, busy_ok, hi_at1, lo_inj);
            check({vecs[k].name, "_lat"}, lat, vecs[k].exp_lat);
            check({vecs[k].name, "_hi"}, hi, vecs[k].exp_hi);
            check({vecs[k].name, "_lo"}, lo, vecs[k].exp_lo);
        end
        check("div_zero_clear", div_zero, 0);

        // DIVU by zero: full latency, hi = dividend, lo = all ones, sticky flag
        run_op(OP_DIVU, 32'h1234_5678, 32'd0, 0, 1'b0, lat, busy_ok, hi_at1, lo_inj);
        check("dz_lat", lat, W + 2);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        check("dz_hi", hi, 32'h1234_5678);
        check("dz_flag", div_zero, 1);

        // MULTU 6*7 with a second start and an MTLO while busy; both ignored
        inj_cycle = EARLY ? 2 : 10;
        run_op(OP_MULTU, 32'd6, 32'd7, inj_cycle, 1'b0, lat, busy_ok, hi_at1, lo_inj);
        check("busy_mtlo_ignored", lo_inj, 32'hFFFF_FFFF);
        check("multu67_lat", lat, mul_lat(32'd7));
        check("multu67_lo", lo, 32'h2A);
        check("multu67_hi", hi, 32'h0);
        check("dz_sticky", div_zero, 1);
        extra_done = 0;
        repeat (40) begin
            @(negedge clk_cpu);
            if (done) extra_done++;
        end
        check("no_second_done", extra_done, 0);

        // Signed divide by zero reports the raw dividend bits
        run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, 0, 1'b0, lat, busy_ok, hi_at1, lo_inj);
        check("sdz_lo", lo, 32'hFFFF_FFFF);
        check("sdz_hi", hi, 32'hFFFF_FFF0);

        // Reset asserted mid-divide clears everything immediately
        @(negedge clk_cpu);
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd7;
        b     = 32'hFFFF_FFFE;
        @(negedge clk_cpu);
        start = 1'b0;
        repeat (14) @(negedge clk_cpu);
        check("pre_reset_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_div_zero", div_zero, 0);
        @(negedge clk_cpu);
        reset = 1'b1;

        run_op(OP_MULTU, 32'd2, 32'd3, 0, 1'b0, lat, busy_ok, hi_at1, lo_inj);
        check("post_rst_lat", lat, mul_lat(32'd3));
        check("post_rst_lo", lo, 32'h6);
        check("post_rst_hi", hi, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
